// File: rtl/data_mem_load_unit.sv
// Load unit: issues one or two word reads and returns an extracted, extended byte/half/word/dword.
// Latency: fault 1 cycle, single-word load 3 cycles, word-crossing load 5 cycles after acceptance.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
module data_mem_load_unit #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_select,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, FETCH0, WAIT0, FETCH1, WAIT1, RESP} state_t;

    state_t state, state_nx;

    logic [XLEN-1:0]   addr_q;
    logic [2:0]        sel_q;
    logic [XLEN-1:0]   word0_q;
    logic [XLEN-1:0]   aligned_addr;
    logic [3:0]        off_in;
    logic [3:0]        off_q;
    logic              req_fault;
    logic              crossing;
    logic [2*XLEN-1:0] cat;
    logic [XLEN-1:0]   window;
    logic [XLEN-1:0]   result;

    // Access size in bytes; 0 marks the illegal encoding.
    function automatic logic [3:0] size_of(input logic [2:0] sel);
        case (sel)
            3'b000, 3'b011: return 4'd1;
            3'b001, 3'b100: return 4'd2;
            3'b010, 3'b101: return 4'd4;
            3'b110:         return 4'd8;
            default:        return 4'd0;
        endcase
    endfunction

    // LWU and LD only exist on a 64-bit datapath.
    function automatic logic is_illegal(input logic [2:0] sel);
        return (sel == 3'b111) || ((XLEN == 32) && ((sel == 3'b101) || (sel == 3'b110)));
    endfunction

    // Request decode, address alignment and word-crossing detection.
    always_comb begin
        off_in       = 4'(req_addr[OFFW-1:0]);
        off_q        = 4'(addr_q[OFFW-1:0]);
        aligned_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
        req_fault    = is_illegal(req_select) ||
                       (!ALLOW_MISALIGNED && ((off_in & (size_of(req_select) - 4'd1)) != 4'd0));
        crossing     = (5'(off_q) + 5'(size_of(sel_q))) > 5'(BYTES);
    end

    // Field extraction: shift the addressed byte to the top of {word0, word1}, then extend.
    always_comb begin
        cat    = (state == WAIT1) ? {word0_q, mem_rdata} : {mem_rdata, {XLEN{1'b0}}};
        window = XLEN'((cat << {addr_q[OFFW-1:0], 3'b000}) >> XLEN);
        result = '0;
        case (sel_q)
            3'b000:  result = XLEN'(window[XLEN-1 -: 8]);
            3'b011:  result = XLEN'($signed(window[XLEN-1 -: 8]));
            3'b001:  result = XLEN'(window[XLEN-1 -: 16]);
            3'b100:  result = XLEN'($signed(window[XLEN-1 -: 16]));
            3'b010:  result = XLEN'($signed(window[XLEN-1 -: 32]));
            3'b101:  result = XLEN'(window[XLEN-1 -: 32]);
            3'b110:  result = window;
            default: result = '0;
        endcase
    end

    // State register; reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_fault ? RESP : FETCH0;
            FETCH0:  state_nx = WAIT0;
            WAIT0:   state_nx = crossing ? FETCH1 : RESP;
            FETCH1:  state_nx = WAIT1;
            WAIT1:   state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; second read address wraps naturally at 2^XLEN.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_rd_en  = (state == FETCH0) || (state == FETCH1);
        mem_addr   = '0;
        if (state == FETCH0)      mem_addr = aligned_addr;
        else if (state == FETCH1) mem_addr = aligned_addr + XLEN'(BYTES);
    end

    // Request capture, first-word capture and response register (loaded on entry to RESP).
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            sel_q      <= '0;
            word0_q    <= '0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q <= req_addr;
                    sel_q  <= req_select;
                    if (req_fault) begin
                        resp_data  <= '0;
                        resp_fault <= 1'b1;
                    end
                end
                WAIT0: begin
                    word0_q <= mem_rdata;
                    if (!crossing) begin
                        resp_data  <= result;
                        resp_fault <= 1'b0;
                    end
                end
                WAIT1: begin
                    resp_data  <= result;
                    resp_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
